flow_ctrl: RTL and testbench
============================

Name: flow_ctrl

Overview:
Sequencer for the `flow` shift chain (NUM+1 stages × WIDTH bits). The chain shifts on every clock, so this block accepts a valid/ready sample stream and chooses what enters stage 0 each cycle: a real sample (`flow_en`=1) or a bubble (`init_x`). It keeps a per-stage valid map aligned with the chain contents and flags when the whole window holds real samples. It also runs start/flush sequences and counts accepted samples.

Parameters:
- NUM, 3, chain depth minus one; the chain has NUM+1 stages. Legal range 0 and up.
- WIDTH, 8, sample width in bits.
- CNT_W, 16, width of the accepted-sample counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to begin streaming; honoured only in IDLE.
- flush  in  1  one-cycle request to drain the chain; honoured only in FILL or RUN.
- init_val  in  WIDTH  bubble value pushed when no sample is accepted.
- s_valid  in  1  upstream sample valid.
- s_data  in  WIDTH  upstream sample.
- s_ready  out  1  sample accepted on this edge when s_valid && s_ready.
- flow_en  out  1  to chain `en`.
- flow_x  out  WIDTH  to chain `x`.
- flow_init_x  out  WIDTH  to chain `init_x`.
- stage_vld  out  NUM+1  bit i = chain stage i holds a real sample.
- win_valid  out  1  all stages hold real samples.
- busy  out  1  state != IDLE.
- state  out  2  IDLE=0, FILL=1, RUN=2, FLUSH=3.
- sample_cnt  out  CNT_W  samples accepted since the last start.
- done  out  1  one-cycle pulse when a flush completes.

Behaviour:
- Reset (async, rst=1): state=IDLE, stage_vld=0, sample_cnt=0, flush counter=0, done=0. Combinational outputs follow from these: s_ready=0, flow_en=0, win_valid=0, busy=0.
- Combinational datapath:
  - s_ready = (state==FILL || state==RUN) && !flush.
  - flow_en = s_valid && s_ready.
  - flow_x = s_data.
  - flow_init_x = init_val.
- Valid map, every edge: stage_vld <= {stage_vld[NUM-1:0], flow_en}. For NUM=0: stage_vld <= flow_en.
  - The map tracks the chain exactly with zero latency: after the edge that accepts sample k, stage 0 and stage_vld[0] both reflect k.
- win_valid = &stage_vld, combinational from registers.
- FSM transitions:
  - IDLE: chain receives bubbles; stage_vld drains to 0. On start: sample_cnt<=0, go to FILL. flush is ignored.
  - FILL: if flush, go to FLUSH (or IDLE when NUM=0). Else if the next stage_vld is all ones, go to RUN.
  - RUN: if flush, go to FLUSH (or IDLE when NUM=0). Else if a bubble enters (flow_en=0), go to FILL.
  - FLUSH: s_ready=0, bubbles are pushed. The counter loads NUM-1 on entry and decrements each cycle; at 0, go to IDLE.
  - FLUSH length: the flush cycle itself pushes bubble 1, and FLUSH lasts exactly NUM cycles, for NUM+1 bubbles in total.
- done: registered. Asserted for exactly the first cycle in IDLE after a flush, when stage_vld==0. For NUM=0, asserted the cycle after flush.
- start outside IDLE is ignored. start and flush in the same cycle: only the one legal in the current state acts.
- sample_cnt: +1 on every edge with flow_en=1. Saturates at 2^CNT_W−1; never wraps. Holds its value through FLUSH and IDLE until the next start.
- s_valid with s_ready=0 is not consumed. Upstream holds s_data; no data is stored here.
- Reset asserted mid-FILL, RUN or FLUSH: immediately returns to reset values. No done pulse. Chain contents are not drained.

Test Plan:
1. NUM=3: reset, start, then s_data=0x11,0x22,0x33,0x44 on consecutive cycles → stage_vld goes 0001, 0011, 0111, 1111. win_valid=1 and state=RUN after the 4th edge. sample_cnt=4.
2. In RUN, drop s_valid for one cycle, then resume → flow_en=0, state=FILL, stage_vld=1110. win_valid returns after 4 more consecutive accepts.
3. Flush in RUN with s_valid=1 → s_ready=0 that cycle, sample not consumed. FLUSH lasts 3 cycles. done pulses 1 cycle with stage_vld=0000, state=IDLE, sample_cnt unchanged.
4. Start and flush together in IDLE → FILL entered, sample_cnt=0, no done. Start pulsed in RUN → no effect.
5. CNT_W=4: 20 accepts → sample_cnt sticks at 15.
6. Assert rst mid-FLUSH → all outputs at reset values asynchronously, no done. NUM=0 build: flush gives done on the next cycle.

Source files
------------

// File: rtl/flow_ctrl.sv
// Sequencer for the flow shift chain: picks sample or bubble for stage 0 each cycle,
// tracks per-stage validity, and runs start/flush sequences with a saturating sample count.
module flow_ctrl #(
  parameter int NUM   = 3,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] init_val,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             flow_en,
  output logic [WIDTH-1:0] flow_x,
  output logic [WIDTH-1:0] flow_init_x,
  output logic [NUM:0]     stage_vld,
  output logic             win_valid,
  output logic             busy,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Flush counter only needs to hold NUM-1; keep at least one bit for NUM<=1.
  localparam int FCW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [FCW-1:0]   FLUSH_LOAD = (NUM > 0) ? FCW'(NUM - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_reg, state_next;
  logic [NUM:0]     stage_vld_reg, stage_vld_next;
  logic [FCW-1:0]   flush_cnt_reg, flush_cnt_next;
  logic [CNT_W-1:0] sample_cnt_reg, sample_cnt_next;
  logic             done_reg, done_next;
  logic             streaming;

  assign streaming   = (state_reg == FILL) || (state_reg == RUN);
  assign s_ready     = streaming && !flush;
  assign flow_en     = s_valid && s_ready;
  assign flow_x      = s_data;
  assign flow_init_x = init_val;

  // Valid map mirrors the chain: new entry at bit 0, everything else moves up one stage.
  assign stage_vld_next[0] = flow_en;
  generate
    for (genvar gi = 1; gi <= NUM; gi++) begin : g_vld_shift
      assign stage_vld_next[gi] = stage_vld_reg[gi-1];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    flush_cnt_next  = flush_cnt_reg;
    sample_cnt_next = sample_cnt_reg;
    done_next       = 1'b0;

    if (flow_en && (sample_cnt_reg != CNT_MAX)) begin
      sample_cnt_next = sample_cnt_reg + CNT_W'(1);
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          sample_cnt_next = '0;
          state_next      = FILL;
        end
      end
      FILL, RUN: begin
        if (flush) begin
          // A single-stage chain is already empty after the bubble pushed this cycle.
          if (NUM == 0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next     = FLUSH;
            flush_cnt_next = FLUSH_LOAD;
          end
        end else if (state_reg == FILL) begin
          if (&stage_vld_next) begin
            state_next = RUN;
          end
        end else if (!flow_en) begin
          state_next = FILL;
        end
      end
      FLUSH: begin
        if (flush_cnt_reg == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          flush_cnt_next = flush_cnt_reg - FCW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      stage_vld_reg  <= '0;
      flush_cnt_reg  <= '0;
      sample_cnt_reg <= '0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      stage_vld_reg  <= stage_vld_next;
      flush_cnt_reg  <= flush_cnt_next;
      sample_cnt_reg <= sample_cnt_next;
      done_reg       <= done_next;
    end
  end

  assign stage_vld  = stage_vld_reg;
  assign win_valid  = &stage_vld_reg;
  assign busy       = (state_reg != IDLE);
  assign state      = state_reg;
  assign sample_cnt = sample_cnt_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_flow_ctrl.sv
// Bench for flow_ctrl: NUM=3/CNT_W=16 instance with a data scoreboard, plus a
// NUM=0/CNT_W=4 instance for the single-stage flush and counter saturation.
module tb_flow_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance
  logic        start, flush, s_valid;
  logic [7:0]  init_val, s_data;
  logic        s_ready, flow_en, win_valid, busy, done;
  logic [7:0]  flow_x, flow_init_x;
  logic [3:0]  stage_vld;
  logic [1:0]  state;
  logic [15:0] sample_cnt;

  // single-stage instance
  logic        start0, flush0, s_valid0;
  logic [7:0]  s_data0;
  logic        s_ready0, flow_en0, win_valid0, busy0, done0;
  logic [7:0]  flow_x0, flow_init_x0;
  logic [0:0]  stage_vld0;
  logic [1:0]  state0;
  logic [3:0]  sample_cnt0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb_q[$];

  flow_ctrl #(.NUM(3), .WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .init_val(init_val),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .flow_en(flow_en),
    .flow_x(flow_x), .flow_init_x(flow_init_x), .stage_vld(stage_vld),
    .win_valid(win_valid), .busy(busy), .state(state), .sample_cnt(sample_cnt),
    .done(done)
  );

  flow_ctrl #(.NUM(0), .WIDTH(8), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .flush(flush0), .init_val(init_val),
    .s_valid(s_valid0), .s_data(s_data0), .s_ready(s_ready0), .flow_en(flow_en0),
    .flow_x(flow_x0), .flow_init_x(flow_init_x0), .stage_vld(stage_vld0),
    .win_valid(win_valid0), .busy(busy0), .state(state0), .sample_cnt(sample_cnt0),
    .done(done0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted sample must be the next one the bench queued.
  always @(negedge clk) begin
    if (!rst && flow_en) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_extra_accept", 32'(flow_en), 32'd0);
      end else begin
        logic [7:0] exp_d;
        exp_d = sb_q.pop_front();
        check_eq("sb_data", 32'(flow_x), 32'(exp_d));
        $display("accept data=0x%02h stage_vld=%b cnt=%0d", flow_x, stage_vld, sample_cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d1 [4];
    logic [3:0] v1 [4];
    logic [7:0] d2 [4];
    logic [3:0] v2 [4];
    int n;
    d1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    v1 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    d2 = '{8'h55, 8'h66, 8'h77, 8'h88};
    v2 = '{4'b1101, 4'b1011, 4'b0111, 4'b1111};

    rst = 1'b1;
    start = 0; flush = 0; s_valid = 0; s_data = 8'h00; init_val = 8'hA5;
    start0 = 0; flush0 = 0; s_valid0 = 0; s_data0 = 8'h00;
    #2;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_stage_vld", 32'(stage_vld), 32'd0);
    check_eq("rst_cnt", 32'(sample_cnt), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_win_valid", 32'(win_valid), 32'd0);
    check_eq("init_x_pass", 32'(flow_init_x), 32'hA5);
    tick();
    rst = 1'b0;
    tick();

    // 1: start then fill the window
    start = 1;
    tick();
    start = 0;
    check_eq("start_state", 32'(state), 32'd1);
    check_eq("start_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_data = d1[i];
      sb_q.push_back(d1[i]);
      #1;
      check_eq("fill_s_ready", 32'(s_ready), 32'd1);
      check_eq("fill_flow_x", 32'(flow_x), 32'(d1[i]));
      tick();
      check_eq("fill_stage_vld", 32'(stage_vld), 32'(v1[i]));
      check_eq("fill_state", 32'(state), (i == 3) ? 32'd2 : 32'd1);
    end
    check_eq("fill_win_valid", 32'(win_valid), 32'd1);
    check_eq("fill_cnt", 32'(sample_cnt), 32'd4);

    // 2: one-cycle bubble in RUN
    s_valid = 0;
    #1;
    check_eq("bubble_flow_en", 32'(flow_en), 32'd0);
    tick();
    check_eq("bubble_state", 32'(state), 32'd1);
    check_eq("bubble_stage_vld", 32'(stage_vld), 32'hE);
    check_eq("bubble_win_valid", 32'(win_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_data = d2[i];
      sb_q.push_back(d2[i]);
      tick();
      check_eq("refill_stage_vld", 32'(stage_vld), 32'(v2[i]));
      check_eq("refill_win_valid", 32'(win_valid), (i == 3) ? 32'd1 : 32'd0);
    end
    check_eq("refill_state", 32'(state), 32'd2);
    check_eq("refill_cnt", 32'(sample_cnt), 32'd8);

    // 3: flush in RUN with a sample offered; it must not be consumed
    flush = 1; s_valid = 1; s_data = 8'h99;
    #1;
    check_eq("flush_s_ready", 32'(s_ready), 32'd0);
    check_eq("flush_flow_en", 32'(flow_en), 32'd0);
    tick();
    flush = 0; s_valid = 0;
    check_eq("flush_state", 32'(state), 32'd3);
    check_eq("flush_stage_vld", 32'(stage_vld), 32'hE);
    n = 0;
    while (state == 2'd3 && n < 10) begin
      check_eq("flush_no_early_done", 32'(done), 32'd0);
      tick();
      n++;
    end
    check_eq("flush_cycles", 32'(n), 32'd3);
    check_eq("flush_done", 32'(done), 32'd1);
    check_eq("flush_idle", 32'(state), 32'd0);
    check_eq("flush_drained", 32'(stage_vld), 32'd0);
    check_eq("flush_cnt_hold", 32'(sample_cnt), 32'd8);
    tick();
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("idle_cnt_hold", 32'(sample_cnt), 32'd8);

    // 4: start+flush together in IDLE, then start ignored in RUN
    start = 1; flush = 1;
    tick();
    start = 0; flush = 0;
    check_eq("sf_state", 32'(state), 32'd1);
    check_eq("sf_cnt", 32'(sample_cnt), 32'd0);
    check_eq("sf_done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_data = 8'hC0 + 8'(i);
      sb_q.push_back(8'hC0 + 8'(i));
      tick();
    end
    check_eq("run_again", 32'(state), 32'd2);
    start = 1; s_data = 8'hD0;
    sb_q.push_back(8'hD0);
    tick();
    start = 0; s_valid = 0;
    check_eq("start_in_run_state", 32'(state), 32'd2);
    check_eq("start_in_run_cnt", 32'(sample_cnt), 32'd5);

    // 6a: async reset in the middle of FLUSH
    flush = 1;
    tick();
    flush = 0;
    check_eq("pre_rst_flush", 32'(state), 32'd3);
    tick();
    #1;
    rst = 1;
    #1;
    check_eq("arst_state", 32'(state), 32'd0);
    check_eq("arst_stage_vld", 32'(stage_vld), 32'd0);
    check_eq("arst_cnt", 32'(sample_cnt), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    #2;
    rst = 0;
    tick();
    check_eq("post_rst_done", 32'(done), 32'd0);
    check_eq("post_rst_state", 32'(state), 32'd0);

    // 5 + 6b: single-stage build, counter saturation and one-cycle flush
    start0 = 1;
    tick();
    start0 = 0;
    check_eq("n0_start_state", 32'(state0), 32'd1);
    for (int i = 0; i < 20; i++) begin
      s_valid0 = 1; s_data0 = 8'(i);
      tick();
      if (i == 0) begin
        check_eq("n0_run_state", 32'(state0), 32'd2);
        check_eq("n0_win_valid", 32'(win_valid0), 32'd1);
      end
      if (i == 13) check_eq("n0_cnt_14", 32'(sample_cnt0), 32'd14);
    end
    $display("n0 accepts=20 sample_cnt=%0d", sample_cnt0);
    check_eq("n0_cnt_sat", 32'(sample_cnt0), 32'd15);
    flush0 = 1;
    #1;
    check_eq("n0_flush_s_ready", 32'(s_ready0), 32'd0);
    tick();
    flush0 = 0; s_valid0 = 0;
    check_eq("n0_done", 32'(done0), 32'd1);
    check_eq("n0_idle", 32'(state0), 32'd0);
    check_eq("n0_drained", 32'(stage_vld0), 32'd0);
    check_eq("n0_cnt_hold", 32'(sample_cnt0), 32'd15);
    tick();
    check_eq("n0_done_one_cycle", 32'(done0), 32'd0);

    check_eq("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
